// File: rtl/mem_access_ctrl_if.sv
// Data-bus handshake bundle between the M-stage load/store controller and memory.
// Driven fields are registered by the controller; ack/rdata come back from the bus.
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage load/store controller: alignment check, byte-lane steering and a
// req/ack bus transaction with timeout, stalling the pipeline while outstanding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  st_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] rdata_raw,
  output logic [1:0]  rdata_off,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg,  state_next;
  logic [7:0]  cnt_reg,    cnt_next;
  logic        req_reg,    req_next;
  logic        we_reg,     we_next;
  logic [31:0] baddr_reg,  baddr_next;
  logic [3:0]  byteen_reg, byteen_next;
  logic [31:0] bwdata_reg, bwdata_next;
  logic [31:0] raw_reg,    raw_next;
  logic [1:0]  off_reg,    off_next;
  logic        err_reg,    err_next;

  logic        misaligned;
  logic [3:0]  lane_byteen;
  logic [31:0] lane_wdata;

  always_comb begin
    misaligned = 1'b0;
    if (mem_we) begin
      case (st_op)
        2'b00:   misaligned = (addr[1:0] != 2'b00);
        2'b01:   misaligned = addr[0];
        default: misaligned = 1'b0;
      endcase
    end else begin
      case (ld_op)
        3'b000:        misaligned = (addr[1:0] != 2'b00);
        3'b011, 3'b100: misaligned = addr[0];
        default:       misaligned = 1'b0;
      endcase
    end
  end

  assign addr_err = mem_req & misaligned;

  // Store data is replicated across all lanes; byte enables pick the live ones.
  always_comb begin
    lane_byteen = 4'b1111;
    lane_wdata  = wdata;
    if (mem_we) begin
      case (st_op)
        2'b00: begin
          lane_byteen = 4'b1111;
          lane_wdata  = wdata;
        end
        2'b01: begin
          lane_byteen = addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata  = {2{wdata[15:0]}};
        end
        default: begin
          lane_byteen = 4'b0001 << addr[1:0];
          lane_wdata  = {4{wdata[7:0]}};
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    req_next    = req_reg;
    we_next     = we_reg;
    baddr_next  = baddr_reg;
    byteen_next = byteen_reg;
    bwdata_next = bwdata_reg;
    raw_next    = raw_reg;
    off_next    = off_reg;
    err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (mem_req && !misaligned) begin
          req_next    = 1'b1;
          we_next     = mem_we;
          baddr_next  = {addr[31:2], 2'b00};
          byteen_next = lane_byteen;
          bwdata_next = lane_wdata;
          cnt_next    = 8'd0;
          if (!mem_we)
            off_next = addr[1:0];
          state_next  = WAIT;
        end
      end
      WAIT: begin
        // An ack arriving on the threshold cycle still completes normally.
        if (bus.bus_ack) begin
          if (!we_reg)
            raw_next = bus.bus_rdata;
          req_next   = 1'b0;
          state_next = DONE;
        end else if (cnt_reg == TO_LAST) begin
          if (!we_reg)
            raw_next = 32'd0;
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      baddr_reg  <= 32'd0;
      byteen_reg <= 4'd0;
      bwdata_reg <= 32'd0;
      raw_reg    <= 32'd0;
      off_reg    <= 2'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      req_reg    <= req_next;
      we_reg     <= we_next;
      baddr_reg  <= baddr_next;
      byteen_reg <= byteen_next;
      bwdata_reg <= bwdata_next;
      raw_reg    <= raw_next;
      off_reg    <= off_next;
      err_reg    <= err_next;
    end
  end

  // Gated by reset so the pipeline is released the instant reset hits.
  assign stall = ~reset & mem_req & ~misaligned & (state_reg != DONE);

  assign bus_err        = err_reg;
  assign rdata_raw      = raw_reg;
  assign rdata_off      = off_reg;
  assign bus.bus_req    = req_reg;
  assign bus.bus_we     = we_reg;
  assign bus.bus_addr   = baddr_reg;
  assign bus.bus_byteen = byteen_reg;
  assign bus.bus_wdata  = bwdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; acts as pipeline and bus slave.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [2:0]  ld_op;
  logic [1:0]  st_op;
  logic [31:0] addr, wdata;
  logic        stall, addr_err, bus_err;
  logic [31:0] rdata_raw;
  logic [1:0]  rdata_off;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ld_op     (ld_op),
    .st_op     (st_op),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .rdata_raw (rdata_raw),
    .rdata_off (rdata_off),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Results captured by run_txn for the caller to check.
  int          n_stall, n_wait;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_byteen;
  logic        c_we, c_err;

  // Issue one access; ack_after = number of no-ack WAIT cycles before ack (-1 = never).
  // Called at posedge+1; returns in the DONE cycle at posedge+2 with mem_req still high.
  task automatic run_txn(input logic we, input logic [2:0] lop, input logic [1:0] sop,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_after, input logic [31:0] rd);
    bit seen_req = 0;
    mem_req = 1'b1; mem_we = we; ld_op = lop; st_op = sop; addr = a; wdata = wd;
    bus.bus_ack = 1'b0;
    n_stall = 0; n_wait = 0; c_err = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (!stall) begin
        c_err = bus_err;
        return;
      end
      n_stall++;
      if (bus.bus_req) begin
        if (!seen_req) begin
          seen_req = 1;
          c_addr = bus.bus_addr; c_wdata = bus.bus_wdata;
          c_byteen = bus.bus_byteen; c_we = bus.bus_we;
        end
        if (ack_after >= 0 && n_wait == ack_after) begin
          bus.bus_ack = 1'b1;
          bus.bus_rdata = rd;
        end
        n_wait++;
      end
      @(posedge clk); #1;
      bus.bus_ack = 1'b0;
      bus.bus_rdata = 32'h0BAD_0BAD;
    end
    chk("txn_budget", 32'd1, 32'd0);
  endtask

  // Leave DONE: drop mem_req and step into the next cycle.
  task automatic finish_txn();
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; ld_op = 3'b000; st_op = 2'b00;
    addr = 32'd0; wdata = 32'd0; bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",   {31'd0, stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_addr",    bus.bus_addr, 32'd0);
    chk("rst_rdata",   rdata_raw, 32'd0);
    chk("rst_off",     {30'd0, rdata_off}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // lw, zero wait states
    run_txn(1'b0, 3'b000, 2'b00, 32'h0000_1000, 32'd0, 0, 32'hDEAD_BEEF);
    $display("txn lw  0x1000: stall=%0d waits=%0d rdata=0x%08h", n_stall, n_wait, rdata_raw);
    chk("lw_addr",   c_addr, 32'h0000_1000);
    chk("lw_byteen", {28'd0, c_byteen}, 32'hF);
    chk("lw_stall",  n_stall, 32'd2);
    chk("lw_rdata",  rdata_raw, 32'hDEAD_BEEF);
    chk("lw_off",    {30'd0, rdata_off}, 32'd0);
    chk("lw_done_req", {31'd0, bus.bus_req}, 32'd0);
    finish_txn();

    // sb: lane 3, rdata_raw must not change
    run_txn(1'b1, 3'b000, 2'b10, 32'h0000_2003, 32'h0000_00A5, 0, 32'hFFFF_FFFF);
    $display("txn sb  0x2003: stall=%0d byteen=%b wdata=0x%08h", n_stall, c_byteen, c_wdata);
    chk("sb_byteen", {28'd0, c_byteen}, 32'h8);
    chk("sb_wdata",  c_wdata, 32'hA5A5_A5A5);
    chk("sb_we",     {31'd0, c_we}, 32'd1);
    chk("sb_addr",   c_addr, 32'h0000_2000);
    chk("sb_rdata_keep", rdata_raw, 32'hDEAD_BEEF);
    finish_txn();

    // sh, ack after 3 wait cycles
    run_txn(1'b1, 3'b000, 2'b01, 32'h0000_2002, 32'h0000_1234, 3, 32'd0);
    $display("txn sh  0x2002: stall=%0d byteen=%b wdata=0x%08h", n_stall, c_byteen, c_wdata);
    chk("sh_byteen", {28'd0, c_byteen}, 32'hC);
    chk("sh_wdata",  c_wdata, 32'h1234_1234);
    chk("sh_stall",  n_stall, 32'd5);
    finish_txn();

    // misaligned lh then lw
    mem_req = 1'b1; mem_we = 1'b0; ld_op = 3'b100; addr = 32'h0000_3001;
    for (int k = 0; k < 2; k++) begin
      #1;
      $display("txn %s 0x%08h: addr_err=%0d stall=%0d", (k == 0) ? "lh" : "lw", addr, addr_err, stall);
      chk("mis_err",   {31'd0, addr_err}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk("mis_no_req", {31'd0, bus.bus_req}, 32'd0);
      end
      ld_op = 3'b000; addr = 32'h0000_3002;
    end
    finish_txn();

    // lw timeout
    run_txn(1'b0, 3'b000, 2'b00, 32'h0000_6000, 32'd0, -1, 32'd0);
    $display("txn lw  0x6000 timeout: stall=%0d waits=%0d bus_err=%0d", n_stall, n_wait, c_err);
    chk("to_waits", n_wait, 32'd16);
    chk("to_err",   {31'd0, c_err}, 32'd1);
    chk("to_rdata", rdata_raw, 32'd0);
    finish_txn();
    chk("to_err_pulse", {31'd0, bus_err}, 32'd0);

    // ack exactly on the threshold cycle wins
    run_txn(1'b0, 3'b000, 2'b00, 32'h0000_7000, 32'd0, 15, 32'hCAFE_F00D);
    $display("txn lw  0x7000 late ack: waits=%0d bus_err=%0d rdata=0x%08h", n_wait, c_err, rdata_raw);
    chk("late_err",   {31'd0, c_err}, 32'd0);
    chk("late_rdata", rdata_raw, 32'hCAFE_F00D);
    finish_txn();

    // reset during WAIT
    mem_req = 1'b1; mem_we = 1'b0; ld_op = 3'b000; addr = 32'h0000_5000;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_req", {31'd0, bus.bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    $display("txn reset in WAIT: bus_req=%0d stall=%0d", bus.bus_req, stall);
    chk("mid_rst_req",   {31'd0, bus.bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    mem_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // lbu after reset
    run_txn(1'b0, 3'b001, 2'b00, 32'h0000_4002, 32'd0, 0, 32'h1122_3344);
    $display("txn lbu 0x4002: stall=%0d off=%0d rdata=0x%08h", n_stall, rdata_off, rdata_raw);
    chk("lbu_off",   {30'd0, rdata_off}, 32'd2);
    chk("lbu_addr",  c_addr, 32'h0000_4000);
    chk("lbu_stall", n_stall, 32'd2);
    chk("lbu_rdata", rdata_raw, 32'h1122_3344);
    finish_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
